mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal 1..15).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 Cancel  input  1  E-stage interrupt request; suppresses the E-stage op in the same cycle.
REQ-007 Data1  input  32  rs operand (forwarded).
REQ-008 Data2  input  32  rt operand (forwarded).
REQ-009 D_isMD  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 Start  output  1  combinational; a multi-cycle op is accepted this cycle.
REQ-011 Busy  output  1  registered; multi-cycle op in progress.
REQ-012 StallReq  output  1  combinational; freeze F/D and bubble E.
REQ-013 HI  output  32  architectural HI register.
REQ-014 LO  output  32  architectural LO register.

Function
REQ-015 States IDLE and RUN; Busy = (state == RUN).
REQ-016 Op accepted when MDOp in {1..6}, Cancel = 0, and state = IDLE; otherwise MDOp is ignored.
REQ-017 Start = accepted & MDOp in {1..4}.
REQ-018 mthi/mtlo accepted: HI (resp. LO) <= Data1 at the same edge; the other register is unchanged; state stays IDLE.
REQ-019 Start in cycle t: at edge t, latch the result into pending registers PHI/PLO, load the 4-bit down-counter with N (MULT_CYCLES or DIV_CYCLES), and move to RUN.
REQ-020 Busy = 1 for cycles t+1 .. t+N exactly; the counter decrements once per RUN cycle.
REQ-021 At the edge ending cycle t+N: HI <= PHI, LO <= PLO, state -> IDLE; new values are visible and Busy = 0 in cycle t+N+1.
REQ-022 A new Start is allowed in cycle t+N+1; back-to-back ops have no extra gap.
REQ-023 mult: {PHI,PLO} = signed Data1 * signed Data2, 64-bit. multu: the same product, unsigned.
REQ-024 div: PLO = signed quotient truncated toward zero; PHI = remainder with the sign of Data1. divu: the unsigned equivalents.
REQ-025 Divisor 0: the op still runs DIV_CYCLES with Busy; at completion PHI/PLO equal the current HI/LO, so HI/LO are unchanged.
REQ-026 Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0.
REQ-027 Cancel has no effect in RUN; an op already started always completes and commits.
REQ-028 StallReq = D_isMD & (Busy | Start).
REQ-029 MDOp arriving in RUN (not expected while StallReq is honoured) is ignored; HI/LO are unaffected except by the running op's commit.

Reset
REQ-030 Reset asserted at any time (including mid-RUN): state = IDLE, counter = 0, HI = LO = PHI = PLO = 0, Busy = 0 without waiting for a clock edge.
REQ-031 A pending op interrupted by reset is discarded and never commits.
REQ-032 In the first cycle after reset release, an op is accepted normally.

Verification
REQ-033 mult with Data1 = 0xFFFFFFFE (-2), Data2 = 3 at cycle t -> Busy high in t+1..t+5; in t+6 HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; with multu the same inputs give HI = 0x00000002, LO = 0xFFFFFFFA.
REQ-034 div with Data1 = -7, Data2 = 2 -> after 10 Busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu with Data1 = 7, Data2 = 0 -> 10 Busy cycles, HI/LO unchanged.
REQ-035 mult issued with Cancel = 1 -> Start = 0, Busy stays 0, HI/LO unchanged; mtlo with Cancel = 1 -> LO unchanged.
REQ-036 D_isMD = 1 throughout a mult -> StallReq = 1 in the Start cycle and in all Busy cycles, 0 in cycle t+6; a second mult issued in t+6 is accepted.
REQ-037 Reset pulse during cycle t+3 of a div -> Busy = 0 and HI = LO = 0 immediately, with no later commit; mthi with 0x12345678 after release -> HI = 0x12345678 on the next cycle.
REQ-038 Parameter override MULT_CYCLES = 1 -> Busy high for exactly one cycle and the result is visible in t+2.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: issues mult/div ops, holds Busy for a fixed
// cycle count, then commits the pending result into the architectural HI/LO pair.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  MDOp,
    input  logic        Cancel,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    input  logic        D_isMD,
    output logic        Start,
    output logic        Busy,
    output logic        StallReq,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] phi;
    logic [31:0] plo;
    logic        accepted;
    logic [63:0] result;
    logic [3:0]  n_load;

    function automatic logic [63:0] mul_result(input logic is_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (is_signed)
            return sa * sb;
        return ua * ub;
    endfunction

    // A zero divisor returns the current HI/LO so the commit leaves them unchanged.
    function automatic logic [63:0] div_result(input logic is_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return {hi, lo};
        if (!is_signed)
            return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    always_comb begin
        accepted = 1'b0;
        Start    = 1'b0;
        result   = {HI, LO};
        n_load   = DIV_N;
        if (state == IDLE && !Cancel && MDOp >= OP_MULT && MDOp <= OP_MTLO)
            accepted = 1'b1;
        if (accepted && MDOp <= OP_DIVU)
            Start = 1'b1;
        case (MDOp)
            OP_MULT:  result = mul_result(1'b1, Data1, Data2);
            OP_MULTU: result = mul_result(1'b0, Data1, Data2);
            OP_DIV:   result = div_result(1'b1, Data1, Data2, HI, LO);
            OP_DIVU:  result = div_result(1'b0, Data1, Data2, HI, LO);
            default:  result = {HI, LO};
        endcase
        if (MDOp == OP_MULT || MDOp == OP_MULTU)
            n_load = MULT_N;
    end

    assign Busy     = (state == RUN);
    assign StallReq = D_isMD & (Busy | Start);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accepted) begin
                        if (MDOp == OP_MTHI) begin
                            HI <= Data1;
                        end else if (MDOp == OP_MTLO) begin
                            LO <= Data1;
                        end else begin
                            {phi, plo} <= result;
                            cnt        <= n_load;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    // cnt == 1 marks the last busy cycle; commit at its closing edge.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        HI    <= phi;
                        LO    <= plo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed and randomized ops compared against an arithmetic
// model of HI/LO and a cycle-count model of Busy/Start/StallReq.
module tb_mdu_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [2:0]  MDOp;
    logic        Cancel;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic        D_isMD;
    logic        Start;
    logic        Busy;
    logic        StallReq;
    logic [31:0] HI;
    logic [31:0] LO;

    logic [2:0]  md_op1;
    logic [31:0] d1a;
    logic [31:0] d1b;
    logic        start1;
    logic        busy1;
    logic        stall1;
    logic [31:0] hi1;
    logic [31:0] lo1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 Clk = ~Clk;

    mdu_ctrl dut (
        .Clk(Clk), .Reset(Reset), .MDOp(MDOp), .Cancel(Cancel),
        .Data1(Data1), .Data2(Data2), .D_isMD(D_isMD),
        .Start(Start), .Busy(Busy), .StallReq(StallReq), .HI(HI), .LO(LO)
    );

    mdu_ctrl #(.MULT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .MDOp(md_op1), .Cancel(1'b0),
        .Data1(d1a), .Data2(d1b), .D_isMD(1'b1),
        .Start(start1), .Busy(busy1), .StallReq(stall1), .HI(hi1), .LO(lo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Expected {HI,LO} after an op, from plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] tq;
        logic [63:0] tr;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin q = sa * sb; tq = q; return tq; end
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb; r = sa % sb; tq = q; tr = r;
                return {tr[31:0], tq[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {hi, lo};
                tq = ua / ub; tr = ua % ub;
                return {tr[31:0], tq[31:0]};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one op in the current cycle and follow it to completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dismd, input logic intrude);
        logic [63:0] r;
        int          n;
        MDOp = op; Data1 = a; Data2 = b; D_isMD = dismd; Cancel = 1'b0;
        #1;
        r = model(op, a, b, exp_hi, exp_lo);
        if (op == 3'd5 || op == 3'd6) begin
            chk("start_move", Start, 1'b0);
            chk("stall_move", StallReq, 1'b0);
            step();
            MDOp = 3'd0;
            {exp_hi, exp_lo} = r;
            chk("move_hi", HI, exp_hi);
            chk("move_lo", LO, exp_lo);
            chk("move_busy", Busy, 1'b0);
            return;
        end
        chk("start", Start, 1'b1);
        chk("stall_start", StallReq, dismd);
        n = (op <= 3'd2) ? 5 : 10;
        step();
        for (int i = 0; i < n; i++) begin
            MDOp   = intrude ? 3'($urandom_range(1, 6)) : 3'd0;
            Cancel = 1'($urandom_range(0, 1));
            Data1  = $urandom;
            #1;
            chk("busy_run", Busy, 1'b1);
            chk("start_run", Start, 1'b0);
            chk("stall_run", StallReq, dismd);
            chk("hi_hold", HI, exp_hi);
            chk("lo_hold", LO, exp_lo);
            step();
        end
        MDOp = 3'd0; Cancel = 1'b0;
        {exp_hi, exp_lo} = r;
        #1;
        chk("busy_done", Busy, 1'b0);
        chk("stall_done", StallReq, 1'b0);
        chk("hi_commit", HI, exp_hi);
        chk("lo_commit", LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        Reset = 1'b1; MDOp = 3'd0; Cancel = 1'b0; Data1 = 32'd0; Data2 = 32'd0; D_isMD = 1'b0;
        md_op1 = 3'd0; d1a = 32'd0; d1b = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", Start, 1'b0);

        // Op presented in the first cycle after release.
        Reset = 1'b0;
        run_op(3'd5, $urandom, 32'd0, 1'b0, 1'b0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        run_op(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divu0_hi", HI, 32'hFFFF_FFFF);
        chk("divu0_lo", LO, 32'hFFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ovf_hi", HI, 32'd0);
        chk("ovf_lo", LO, 32'h8000_0000);

        // Cancelled ops leave everything untouched.
        MDOp = 3'd1; Cancel = 1'b1; Data1 = 32'd5; Data2 = 32'd6; #1;
        chk("cancel_start", Start, 1'b0);
        step();
        chk("cancel_busy", Busy, 1'b0);
        chk("cancel_hi", HI, exp_hi);
        MDOp = 3'd6; Data1 = 32'hDEAD_BEEF; #1;
        step();
        chk("cancel_mtlo", LO, exp_lo);
        MDOp = 3'd0; Cancel = 1'b0;

        // Stall through a mult, then back-to-back mult with no gap.
        run_op(3'd1, $urandom, $urandom, 1'b1, 1'b0);
        run_op(3'd1, $urandom, $urandom, 1'b1, 1'b1);

        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a div discards it.
        run_op(3'd6, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        MDOp = 3'd3; Data1 = 32'd100; Data2 = 32'd7; #1;
        chk("rdiv_start", Start, 1'b1);
        step();
        MDOp = 3'd0;
        step();
        step();
        Reset = 1'b1; #1;
        chk("rmid_busy", Busy, 1'b0);
        chk("rmid_hi", HI, 32'd0);
        chk("rmid_lo", LO, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        Reset = 1'b0;
        MDOp = 3'd5; Data1 = 32'h1234_5678; #1;
        step();
        MDOp = 3'd0;
        exp_hi = 32'h1234_5678;
        chk("rmthi_hi", HI, 32'h1234_5678);
        for (int i = 0; i < 12; i++) begin
            chk("rnocommit_busy", Busy, 1'b0);
            chk("rnocommit_hi", HI, exp_hi);
            chk("rnocommit_lo", LO, exp_lo);
            step();
        end

        // Single-cycle mult instance.
        md_op1 = 3'd1; d1a = 32'hFFFF_FFFE; d1b = 32'd3; #1;
        chk("m1_start", start1, 1'b1);
        step();
        md_op1 = 3'd0;
        chk("m1_busy", busy1, 1'b1);
        chk("m1_stall", stall1, 1'b1);
        step();
        chk("m1_done", busy1, 1'b0);
        chk("m1_hi", hi1, 32'hFFFF_FFFF);
        chk("m1_lo", lo1, 32'hFFFF_FFFA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
